// File: rtl/count_match_fifo_if.sv
// Event stream from count_match_fifo to its consumer: valid/ready with a typed event word.
interface count_match_fifo_if #(
    parameter int WIDTH = 8
);
    logic             evt_valid;
    logic             evt_ready;
    logic [WIDTH+1:0] evt_data;

    modport master (output evt_valid, output evt_data, input evt_ready);
    modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/count_match_fifo.sv
// Compare-match event capture with a small event FIFO and sticky overflow.
// Optional wrap events are compiled in with the CNT_WRAP_EVT_EN macro.
module count_match_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          count_in,
    input  logic                      count_vld,
    input  logic                      cmp_we,
    input  logic [WIDTH-1:0]          cmp_val,
    count_match_fifo_if.master        evt,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      fifo_full,
    output logic                      ovf,
    input  logic                      ovf_clr
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] prev_count;
    logic             prev_vld;
    logic [WIDTH-1:0] cmp_reg;
    logic [WIDTH+1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, rd_nxt;
    logic [LW-1:0]    level, level_nxt, level_after_pop;
    logic [WIDTH+1:0] head, head_nxt, evt_word;
    logic             match, wrap, push, pop, push_acc, drop;

    assign evt.evt_valid = (level != '0);
    assign evt.evt_data  = head;
    assign fifo_level    = level;
    assign fifo_full     = (level == LW'(DEPTH));

    always_comb begin
        match = count_vld && (count_in == cmp_reg) && (!prev_vld || (count_in != prev_count));
`ifdef CNT_WRAP_EVT_EN
        wrap = count_vld && prev_vld && (prev_count == '1) && (count_in == '0);
`else
        wrap = 1'b0;
`endif
        evt_word        = {match && wrap, wrap, count_in};
        push            = match || wrap;
        pop             = evt.evt_valid && evt.evt_ready;
        push_acc        = push && (!fifo_full || pop);
        drop            = push && fifo_full && !pop;
        rd_nxt          = rd_ptr + PW'(pop);
        level_after_pop = level - LW'(pop);
        level_nxt       = level_after_pop + LW'(push_acc);

        // Head is registered so evt_data holds its last value once the FIFO drains;
        // a push into a FIFO that is (or becomes) empty bypasses straight to the head.
        head_nxt = head;
        if (level_nxt != '0) begin
            if (level_after_pop == '0)
                head_nxt = evt_word;
            else
                head_nxt = mem[rd_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc)
            mem[wr_ptr] <= evt_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_count <= '0;
            prev_vld   <= 1'b0;
            cmp_reg    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            head       <= '0;
            ovf        <= 1'b0;
        end else begin
            prev_count <= count_in;
            prev_vld   <= count_vld;
            if (cmp_we)
                cmp_reg <= cmp_val;
            if (push_acc)
                wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_nxt;
            level  <= level_nxt;
            head   <= head_nxt;
            if (drop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end
endmodule

// File: doc/count_match_fifo.md
# count_match_fifo

Event-capture stage that sits directly downstream of the 8-bit loadable counter and consumes its count output. Each cycle it compares the sampled count against a programmable compare register. Each qualifying match (and, optionally, each wrap-around) becomes a typed event word, which is buffered in a small FIFO. Events are drained by a consumer over a valid/ready handshake; drops on a full FIFO are flagged with a sticky overflow bit.

## Interface
- WIDTH, 8: count and compare width.
- DEPTH, 4: FIFO entries; power of two, ≥2.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- count_in  in  WIDTH  counter value.
- count_vld  in  1  count_in is driven. Tie to the inverse of the counter's oe_n. When low, count_in is ignored.
- cmp_we  in  1  write strobe for compare register.
- cmp_val  in  WIDTH  compare value, written when cmp_we=1.
- evt_valid  out  1  FIFO head holds an event (= not empty).
- evt_ready  in  1  consumer accepts head when evt_valid=1.
- evt_data  out  WIDTH+2  head event: {type[1:0], count[WIDTH-1:0]}.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- fifo_full  out  1  fifo_level==DEPTH.
- ovf  out  1  sticky: an event was dropped.
- ovf_clr  in  1  clears ovf.

## Operation
- Sample registers prev_count and prev_vld load count_in and count_vld every cycle. prev_vld resets to 0; prev_count resets to 0.
- cmp_reg resets to 0. When cmp_we=1, cmp_reg loads cmp_val at the edge. Evaluation in that same cycle uses the old cmp_reg.
- Match condition: count_vld && count_in==cmp_reg && (!prev_vld || count_in!=prev_count).
  - A count held constant (load of the same value, or counter stalled) produces exactly one match.
- Wrap condition (macro only): count_vld && prev_vld && prev_count==all-ones && count_in==0.
- Event type:
  - 2'b00: match only.
  - 2'b01: wrap only.
  - 2'b11: both in the same cycle.
  - Count field = count_in.
  - At most one push per cycle.
- Pop occurs when evt_valid && evt_ready.
- Push with the FIFO not full: the event is written.
- Push with the FIFO full:
  - With a same-cycle pop: the event is accepted and the level is unchanged.
  - Without a pop: the event is dropped and ovf is set.
- ovf_clr clears ovf. A drop in the same cycle wins, so ovf stays 1.
- Events leave in strict arrival order; read/write pointers wrap modulo DEPTH.
- evt_data is the head entry while evt_valid=1. It holds its last value when the FIFO is empty; the consumer must ignore it then.

## Timing
- Reset values: evt_valid=0, evt_data=0, fifo_level=0, fifo_full=0, ovf=0, cmp_reg=0, pointers=0.
- Reset mid-operation discards all queued events immediately (asynchronous).
- Because prev_vld=0 after reset, a counter at 0 with cmp_reg=0 yields a match on the first valid cycle.
- Latency:
  - Condition true in cycle N → entry written at the end of N.
  - If the FIFO was empty: evt_valid=1 and evt_data valid in N+1.
- Pop in cycle N → the next entry appears at the head, or evt_valid drops, in N+1.
- No combinational path from evt_ready to evt_valid.
- fifo_full, fifo_level and ovf are registered and update on the same edge as the push/pop.

## Configuration
- CNT_WRAP_EVT_EN:
  - Defined: the wrap condition is compiled in, and types 2'b01/2'b11 can occur.
  - Undefined: wrap logic is absent, only type 2'b00 events are generated, and the type field is always 2'b00.

## Test plan
- cmp_val=0x05, count 0x00..0x09 incrementing, count_vld=1, evt_ready=1 → exactly one event {00,0x05}; evt_valid high in the cycle after count_in=0x05.
- cmp_reg=0x05, count held at 0x05 for 4 cycles → one event only. count_vld=0 with count_in=0x05 → no event.
- DEPTH=4, evt_ready=0, five matches (cmp rewritten to 0x10,0x20,0x30,0x40,0x50 ahead of the counter) → level=4, fifo_full=1, ovf=1 after the fifth. Drain → 0x10,0x20,0x30,0x40 in order. ovf_clr → ovf=0.
- FIFO full, evt_ready=1 and a new match in the same cycle → level stays 4, ovf stays 0, and the new event is last out.
- With the macro: cmp=0x80, count 0xFE,0xFF,0x00 → one event {01,0x00}. With cmp=0x00 → one event {11,0x00}. Without the macro, the same stimulus → no event, then {00,0x00} respectively.
- Two entries queued, reset pulsed mid-stream → evt_valid=0, fifo_level=0, ovf=0, cmp_reg=0 while reset is high. The next push after release appears in the following cycle.
